ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
// Host-to-device PS/2 transmitter: sends command bytes (LED set 0xED, reset 0xFF, typematic 0xF3...) to the keyboard.
// Bus-side byte write from the CPU; drives open-drain PS2 clock/data enables alongside the existing keyboard receiver.
// tx_active lets the receive path ignore line activity during a host transmission.
// PARAMETERS
// INHIBIT_CYCLES  5000    io_read_clk cycles clock is held low before start bit (>=100us @50MHz)
// TIMEOUT_CYCLES  750000  max io_read_clk cycles between device clock falling edges (15ms @50MHz)
// PORTS
// io_read_clk  in   1   system/bus clock; all logic on posedge
// rst          in   1   asynchronous, active-high reset
// dat_i        in   8   byte to transmit (write)
// we_i         in   1   1=write(send byte), 0=read status
// stb_i        in   1   bus strobe
// dat_o        out  8   status: {4'b0, err_overrun, err_nack, err_timeout, busy}
// ack_o        out  1   one-cycle bus acknowledge
// ps2_clk_i    in   1   PS2 clock line as seen at pad (async)
// ps2_data_i   in   1   PS2 data line as seen at pad (async)
// ps2_clk_oe   out  1   1 = pull PS2 clock low; 0 = release
// ps2_data_oe  out  1   1 = pull PS2 data low; 0 = release
// tx_active    out  1   high whenever state != IDLE
// tx_done      out  1   one-cycle pulse on successful ACKed transfer
// BEHAVIOUR
// - Reset (async): state IDLE, ps2_clk_oe=0, ps2_data_oe=0, ack_o=0, dat_o=0, tx_done=0, all err bits 0.
// - Reset mid-transfer releases both lines immediately (no clock edge needed).
// - Bus: cycle with stb_i=1 & ack_o=0 is accepted; ack_o=1 next cycle for exactly one cycle.
// - Accepted write in IDLE: latch dat_i, parity=~^dat_i (odd), enter INHIBIT. Write while busy: byte dropped, err_overrun=1.
// - Accepted read: dat_o loads status on the ack cycle; err_* bits clear after being read (busy unaffected).
// - ps2_clk_i/ps2_data_i pass 2-FF synchronizers; fall = prev_sync & ~sync (one-cycle pulse).
// - States:
//   IDLE: lines released; wait accepted write.
//   INHIBIT: clk_oe=1 for INHIBIT_CYCLES; on terminal count data_oe=1 (start bit) -> RELCLK.
//   RELCLK: clk_oe=0 (data_oe stays 1); clear timeout counter -> SHIFT, bitcnt=0.
//   SHIFT: on each fall: bitcnt 0..7 -> data_oe=~byte[bitcnt] (LSB first); bitcnt 8 -> data_oe=~parity; bitcnt 9 -> data_oe=0 (stop); bitcnt 10 -> sample ps2_data sync -> ACKCHK.
//   ACKCHK: sampled 0 -> WAITIDLE; sampled 1 -> err_nack=1 -> WAITIDLE.
//   WAITIDLE: wait synced clk=1 & data=1; -> IDLE; tx_done pulse only if no NACK on this transfer.
// - Timeout: counter in RELCLK/SHIFT/WAITIDLE, cleared on every fall; at TIMEOUT_CYCLES: both oe=0, err_timeout=1, -> IDLE, no tx_done.
// - bitcnt 4 bits, no wrap past 10. Counters sized $clog2(max param)+1.
// - Fall in same cycle as timeout terminal count: edge wins, counter clears.
// - busy = tx_active = (state != IDLE).
// TESTING
// (bench: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=400, behavioural keyboard model)
// 1 write 0xED -> clk_oe high 20 cycles, start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop released; model ACKs -> tx_done pulse, status 0x00.
// 2 write 0x00 / 0xFF / 0x01 -> parity bits 1 / 1 / 0 sampled by model on rising clock.
// 3 model leaves data high on 11th clock -> no tx_done, status read 0x04, second read 0x00.
// 4 model never clocks after RELCLK -> 400 cycles later both oe=0, state IDLE, status 0x02.
// 5 write 0x55 during active transfer of 0xF3 -> 0xF3 completes unchanged, status 0x08.
// 6 assert rst mid-SHIFT (bit 4) -> ps2_clk_oe=ps2_data_oe=0 same cycle, tx_active=0; next write 0xFF transfers cleanly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, ...) to
// the keyboard. The CPU writes the byte over a simple strobe/ack bus. The
// block then drives the open-drain clock/data pull-down enables: it inhibits
// the clock, presents the start bit and shifts the frame out on device clock
// falling edges. Finally it samples the device ACK. tx_active tells the
// receive path to ignore line activity while a host transmission is running.
//
// Ports
//   io_read_clk  system/bus clock, all logic on posedge
//   rst          asynchronous, active-high reset
//   dat_i        byte to transmit on a write
//   we_i         1 = write (send byte), 0 = read status
//   stb_i        bus strobe
//   dat_o        status {4'b0, err_overrun, err_nack, err_timeout, busy}
//   ack_o        one-cycle bus acknowledge
//   ps2_clk_i    PS/2 clock as seen at the pad (asynchronous)
//   ps2_data_i   PS/2 data as seen at the pad (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
//   tx_active    high whenever the transmitter is not idle
//   tx_done      one-cycle pulse after a transfer the device ACKed

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       io_read_clk,
  input  logic       rst,
  input  logic [7:0] dat_i,
  input  logic       we_i,
  input  logic       stb_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RELCLK,
    S_SHIFT,
    S_ACKCHK,
    S_WAITIDLE
  } state_t;

  state_t        state;
  logic [7:0]    tx_byte;
  logic          parity;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] inh_cnt;
  logic [CW-1:0] to_cnt;
  logic          ack_sample;
  logic          nack_seen;
  logic          err_overrun;
  logic          err_nack;
  logic          err_timeout;

  // Two-flop synchronizers. Reset to 1 because an idle PS/2 line floats high.
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       fall;
  logic       accept;
  logic [7:0] status;

  always_ff @(posedge io_read_clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let each flop take the value its
      // neighbour had before the edge, which makes this a real shift chain.
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall      = clk_prev & ~clk_sync[1];
  assign accept    = stb_i & ~ack_o;
  assign tx_active = (state != S_IDLE);
  assign status    = {4'b0000, err_overrun, err_nack, err_timeout, tx_active};

  always_ff @(posedge io_read_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tx_byte     <= 8'h00;
      parity      <= 1'b0;
      bit_cnt     <= 4'd0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ack_sample  <= 1'b0;
      nack_seen   <= 1'b0;
      err_overrun <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
      dat_o       <= 8'h00;
      ack_o       <= 1'b0;
      tx_done     <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      ack_o   <= accept;
      tx_done <= 1'b0;

      // Read-to-clear comes first so an error raised in the same cycle
      // (later assignment below) survives the read.
      if (accept && !we_i) begin
        dat_o       <= status;
        err_overrun <= 1'b0;
        err_nack    <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (accept && we_i && state != S_IDLE) err_overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (accept && we_i) begin
            tx_byte    <= dat_i;
            parity     <= ~^dat_i;
            // The write cycle itself is the first inhibit cycle.
            inh_cnt    <= CW'(1);
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          // RELCLK still holds the clock low for one more cycle, so the
          // terminal count is one early to keep the total at INHIBIT_CYCLES.
          if (inh_cnt >= CW'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;
            state       <= S_RELCLK;
          end else begin
            inh_cnt <= inh_cnt + CW'(1);
          end
        end

        S_RELCLK: begin
          ps2_clk_oe <= 1'b0;
          to_cnt     <= '0;
          bit_cnt    <= 4'd0;
          state      <= S_SHIFT;
        end

        S_SHIFT: begin
          if (fall) begin
            to_cnt <= '0;
            if (bit_cnt < 4'd8)       ps2_data_oe <= ~tx_byte[bit_cnt[2:0]];
            else if (bit_cnt == 4'd8) ps2_data_oe <= ~parity;
            else if (bit_cnt == 4'd9) ps2_data_oe <= 1'b0;
            else begin
              ack_sample <= data_sync[1];
              state      <= S_ACKCHK;
            end
            if (bit_cnt != 4'd10) bit_cnt <= bit_cnt + 4'd1;
          end
        end

        S_ACKCHK: begin
          nack_seen <= ack_sample;
          if (ack_sample) err_nack <= 1'b1;
          to_cnt <= '0;
          state  <= S_WAITIDLE;
        end

        S_WAITIDLE: begin
          if (fall) to_cnt <= '0;
          if (clk_sync[1] && data_sync[1]) begin
            tx_done <= ~nack_seen;
            state   <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Watchdog between device clock edges; an edge in the terminal cycle
      // wins and restarts the count instead.
      if ((state == S_SHIFT || state == S_WAITIDLE) && !fall) begin
        if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          err_timeout <= 1'b1;
          tx_done     <= 1'b0;
          state       <= S_IDLE;
        end else begin
          to_cnt <= to_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx with a behavioural keyboard on the open-drain lines.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 400;

  logic       io_read_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dat_i = 8'h00;
  logic       we_i = 1'b0;
  logic       stb_i = 1'b0;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_active;
  logic       tx_done;

  // Keyboard side of the wired-AND bus: 1 = released.
  logic kbd_clk = 1'b1;
  logic kbd_data = 1'b1;

  assign ps2_clk_i  = kbd_clk & ~ps2_clk_oe;
  assign ps2_data_i = kbd_data & ~ps2_data_oe;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .io_read_clk(io_read_clk),
    .rst(rst),
    .dat_i(dat_i),
    .we_i(we_i),
    .stb_i(stb_i),
    .dat_o(dat_o),
    .ack_o(ack_o),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_active(tx_active),
    .tx_done(tx_done)
  );

  always #5 io_read_clk = ~io_read_clk;

  always @(negedge io_read_clk) if (tx_done === 1'b1) done_cnt++;

  // Expected frame as the device sees it: bit i of the byte for i<8,
  // then odd parity (1 when the byte has an even number of ones), then stop 1.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic bus_write(input logic [7:0] b);
    @(negedge io_read_clk);
    dat_i = b; we_i = 1'b1; stb_i = 1'b1;
    @(negedge io_read_clk);
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(output logic [7:0] d, output logic a1, output logic a2);
    @(negedge io_read_clk);
    stb_i = 1'b1; we_i = 1'b0;
    @(negedge io_read_clk);
    a1 = ack_o; d = dat_o; stb_i = 1'b0;
    @(negedge io_read_clk);
    a2 = ack_o;
  endtask

  // Keyboard model. Writes the byte, measures the inhibit, then clocks the
  // frame and samples data on each rising clock. After that it ACKs (or not)
  // on the 11th clock. stop_at aborts with the clock held low in that bit;
  // inject_at issues a bus write of 0x55 after that bit.
  task automatic do_transfer(input logic [7:0] b, input bit do_ack, input int inject_at,
                             input int stop_at, output int inh_len, output bit start_low,
                             output logic [9:0] frame, output bit ok);
    int n;
    ok = 1'b1; frame = '0; inh_len = 0;
    bus_write(b);
    while (ps2_clk_oe === 1'b1 && inh_len < 1000) begin
      inh_len++;
      @(negedge io_read_clk);
    end
    if (inh_len >= 1000) ok = 1'b0;
    start_low = (ps2_data_i === 1'b0);
    for (int i = 0; i < 10; i++) begin
      repeat (4) @(negedge io_read_clk);
      kbd_clk = 1'b0;
      if (i == stop_at) begin
        repeat (6) @(negedge io_read_clk);
        return;
      end
      repeat (8) @(negedge io_read_clk);
      kbd_clk = 1'b1;
      frame[i] = ps2_data_i;
      if (i == inject_at) bus_write(8'h55);
    end
    repeat (4) @(negedge io_read_clk);
    kbd_data = do_ack ? 1'b0 : 1'b1;
    repeat (4) @(negedge io_read_clk);
    kbd_clk = 1'b0;
    repeat (8) @(negedge io_read_clk);
    kbd_clk = 1'b1;
    repeat (4) @(negedge io_read_clk);
    kbd_data = 1'b1;
    n = 0;
    while (tx_active === 1'b1 && n < 200) begin
      n++;
      @(negedge io_read_clk);
    end
    if (n >= 200) ok = 1'b0;
    repeat (2) @(negedge io_read_clk);
  endtask

  task automatic test_reset();
    logic [7:0] d; logic a1, a2;
    repeat (3) @(negedge io_read_clk);
    n_checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); else n_pass++;
    n_checks++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); else n_pass++;
    n_checks++; if (ack_o !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack_o); else n_pass++;
    n_checks++; if (dat_o !== 8'h00) $display("FAIL reset_dat_o: got %h want 00", dat_o); else n_pass++;
    n_checks++; if (tx_done !== 1'b0) $display("FAIL reset_tx_done: got %b want 0", tx_done); else n_pass++;
    n_checks++; if (tx_active !== 1'b0) $display("FAIL reset_tx_active: got %b want 0", tx_active); else n_pass++;
    rst = 1'b0;
    bus_read(d, a1, a2);
    n_checks++; if (d !== 8'h00) $display("FAIL reset_status: got %h want 00", d); else n_pass++;
    n_checks++; if (a1 !== 1'b1) $display("FAIL read_ack: got %b want 1", a1); else n_pass++;
    n_checks++; if (a2 !== 1'b0) $display("FAIL read_ack_one_cycle: got %b want 0", a2); else n_pass++;
  endtask

  task automatic test_led_cmd();
    int inh; bit sl, ok; logic [9:0] fr; int d0; logic [7:0] d; logic a1, a2;
    d0 = done_cnt;
    do_transfer(8'hED, 1'b1, -1, -1, inh, sl, fr, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL led_handshake: got %b want 1", ok); else n_pass++;
    n_checks++; if (inh !== INH) $display("FAIL led_inhibit_len: got %0d want %0d", inh, INH); else n_pass++;
    n_checks++; if (sl !== 1'b1) $display("FAIL led_start_bit: got low=%b want 1", sl); else n_pass++;
    n_checks++; if (fr !== frame_of(8'hED)) $display("FAIL led_frame: got %b want %b", fr, frame_of(8'hED)); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL led_tx_done: got %0d pulses want 1", done_cnt - d0); else n_pass++;
    bus_read(d, a1, a2);
    n_checks++; if (d !== 8'h00) $display("FAIL led_status: got %h want 00", d); else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h01};
    logic       pars  [3] = '{1'b1, 1'b1, 1'b0};
    int inh; bit sl, ok; logic [9:0] fr; int d0;
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt;
      do_transfer(bytes[k], 1'b1, -1, -1, inh, sl, fr, ok);
      n_checks++; if (fr[8] !== pars[k]) $display("FAIL parity_%h: got %b want %b", bytes[k], fr[8], pars[k]); else n_pass++;
      n_checks++; if (fr !== frame_of(bytes[k])) $display("FAIL parity_frame_%h: got %b want %b", bytes[k], fr, frame_of(bytes[k])); else n_pass++;
      n_checks++; if (done_cnt - d0 !== 1) $display("FAIL parity_done_%h: got %0d want 1", bytes[k], done_cnt - d0); else n_pass++;
    end
  endtask

  task automatic test_nack();
    int inh; bit sl, ok; logic [9:0] fr; int d0; logic [7:0] b, d; logic a1, a2;
    b = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    do_transfer(b, 1'b0, -1, -1, inh, sl, fr, ok);
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL nack_tx_done: got %0d want 0", done_cnt - d0); else n_pass++;
    bus_read(d, a1, a2);
    n_checks++; if (d !== 8'h04) $display("FAIL nack_status: got %h want 04", d); else n_pass++;
    bus_read(d, a1, a2);
    n_checks++; if (d !== 8'h00) $display("FAIL nack_status_cleared: got %h want 00", d); else n_pass++;
  endtask

  task automatic test_timeout();
    int n, d0; logic [7:0] d; logic a1, a2;
    d0 = done_cnt;
    bus_write(8'($urandom_range(0, 255)));
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin n++; @(negedge io_read_clk); end
    n = 0;
    while (ps2_data_oe === 1'b1 && n < 2000) begin @(negedge io_read_clk); n++; end
    n_checks++; if (n !== TMO) $display("FAIL timeout_len: got %0d want %0d", n, TMO); else n_pass++;
    n_checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL timeout_clk_oe: got %b want 0", ps2_clk_oe); else n_pass++;
    n_checks++; if (tx_active !== 1'b0) $display("FAIL timeout_idle: got %b want 0", tx_active); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL timeout_tx_done: got %0d want 0", done_cnt - d0); else n_pass++;
    bus_read(d, a1, a2);
    n_checks++; if (d !== 8'h02) $display("FAIL timeout_status: got %h want 02", d); else n_pass++;
  endtask

  task automatic test_overrun();
    int inh; bit sl, ok; logic [9:0] fr; int d0; logic [7:0] d; logic a1, a2;
    d0 = done_cnt;
    do_transfer(8'hF3, 1'b1, 3, -1, inh, sl, fr, ok);
    n_checks++; if (fr !== frame_of(8'hF3)) $display("FAIL overrun_frame: got %b want %b", fr, frame_of(8'hF3)); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL overrun_tx_done: got %0d want 1", done_cnt - d0); else n_pass++;
    repeat (40) @(negedge io_read_clk);
    n_checks++; if (tx_active !== 1'b0) $display("FAIL overrun_dropped: got active=%b want 0", tx_active); else n_pass++;
    bus_read(d, a1, a2);
    n_checks++; if (d !== 8'h08) $display("FAIL overrun_status: got %h want 08", d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int inh; bit sl, ok; logic [9:0] fr; int d0;
    // 0xA5 has bit 4 clear, so data is being pulled low when reset hits.
    do_transfer(8'hA5, 1'b1, -1, 4, inh, sl, fr, ok);
    n_checks++; if (ps2_data_oe !== 1'b1) $display("FAIL midrst_pre_data_oe: got %b want 1", ps2_data_oe); else n_pass++;
    n_checks++; if (tx_active !== 1'b1) $display("FAIL midrst_pre_active: got %b want 1", tx_active); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL midrst_release: got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); else n_pass++;
    n_checks++; if (tx_active !== 1'b0) $display("FAIL midrst_active: got %b want 0", tx_active); else n_pass++;
    kbd_clk = 1'b1;
    repeat (2) @(negedge io_read_clk);
    rst = 1'b0;
    repeat (5) @(negedge io_read_clk);
    d0 = done_cnt;
    do_transfer(8'hFF, 1'b1, -1, -1, inh, sl, fr, ok);
    n_checks++; if (ok !== 1'b1 || inh !== INH) $display("FAIL midrst_next_inhibit: got ok=%b len=%0d want 1 %0d", ok, inh, INH); else n_pass++;
    n_checks++; if (fr !== frame_of(8'hFF)) $display("FAIL midrst_next_frame: got %b want %b", fr, frame_of(8'hFF)); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL midrst_next_done: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_random();
    int inh; bit sl, ok, ack; logic [9:0] fr; int d0; logic [7:0] b, d, exp_st; logic a1, a2;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      d0 = done_cnt;
      do_transfer(b, ack, -1, -1, inh, sl, fr, ok);
      n_checks++; if (fr !== frame_of(b)) $display("FAIL rand_frame_%h: got %b want %b", b, fr, frame_of(b)); else n_pass++;
      n_checks++; if (done_cnt - d0 !== (ack ? 1 : 0)) $display("FAIL rand_done_%h: got %0d want %0d", b, done_cnt - d0, ack ? 1 : 0); else n_pass++;
      exp_st = ack ? 8'h00 : 8'h04;
      bus_read(d, a1, a2);
      n_checks++; if (d !== exp_st) $display("FAIL rand_status_%h: got %h want %h", b, d, exp_st); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_led_cmd();
    test_parity();
    test_nack();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
